// File: rtl/latch_word_fifo.sv
// latch_word_fifo: valid/ready FIFO ahead of the latch storage array, with one-hot write strobes.
// Optional macro FIFO_BYPASS_EN adds a same-cycle pass-through path when the FIFO is empty.
module latch_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [PW:0]      count,
  output logic [DEPTH-1:0] word_we
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_PTR = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             empty, full, byp, push, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign in_ready = ~full;
  assign count    = count_q;

`ifdef FIFO_BYPASS_EN
  // Empty FIFO forwards the producer word straight to the consumer.
  assign byp       = empty & in_valid & out_ready;
  assign out_valid = ~empty | in_valid;
  assign out_data  = empty ? in_data : mem_q[rd_ptr_q];
`else
  assign byp       = 1'b0;
  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr_q];
`endif

  assign push = in_valid & ~full & ~byp;
  assign pop  = ~empty & out_ready;

  always_comb begin
    word_we = '0;
    if (push) word_we[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + ONE_PTR : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ONE_PTR : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_latch_word_fifo.sv
// tb_latch_word_fifo: directed plus randomized checks of latch_word_fifo
// against a queue-based reference model.
module tb_latch_word_fifo;

  localparam int W = 8;
  localparam int D = 4;
`ifdef FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [2:0]   count;
  logic [D-1:0] word_we;

  latch_word_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .word_we(word_we)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit armed = 1'b0;
  logic [W-1:0] q[$];
  int wp = 0;

  logic         s_ir, s_ov;
  logic [W-1:0] s_od;
  logic [2:0]   s_cnt;
  logic [D-1:0] s_we;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare at negedge, advance model at posedge.
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit r,
                     input bit rs);
    bit byp, mpush, mpop;
    int n;
    logic [D-1:0] ewe;
    in_valid = v; in_data = d; out_ready = r; rst = rs;
    n = q.size();
    byp = BYP && n == 0 && v && r;
    mpush = v && n < D && !byp;
    mpop = n != 0 && r;
    ewe = mpush ? D'(1) << wp : '0;
    @(negedge clk);
    s_ir = in_ready; s_ov = out_valid; s_od = out_data;
    s_cnt = count; s_we = word_we;
    if (armed) begin
      chk("count", 32'(s_cnt), 32'(n));
      chk("in_ready", 32'(s_ir), 32'(n != D));
      chk("out_valid", 32'(s_ov), 32'(n != 0 || (BYP && v)));
      chk("word_we", 32'(s_we), 32'(ewe));
      if (n != 0) chk("out_data", 32'(s_od), 32'(q[0]));
      else if (BYP && v) chk("byp_data", 32'(s_od), 32'(d));
    end
    @(posedge clk);
    if (rs) begin
      q.delete(); wp = 0; armed = 1'b1;
    end else begin
      if (mpop) void'(q.pop_front());
      if (mpush) begin q.push_back(d); wp = (wp + 1) % D; end
    end
    #1;
  endtask

  logic [W-1:0] seq4 [4];
  logic [D-1:0] we4 [4];

  initial begin
    seq4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    we4  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    @(posedge clk); #1;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      chk("rst_cnt", 32'(s_cnt), 0);
      chk("rst_ov", 32'(s_ov), 0);
      chk("rst_ir", 32'(s_ir), 1);
      chk("rst_we", 32'(s_we), 0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, seq4[i], 0, 0);
      chk("fill_we", 32'(s_we), 32'(we4[i]));
    end
    cyc(1, 8'hE5, 0, 0);
    chk("full_ir", 32'(s_ir), 0);
    chk("full_cnt", 32'(s_cnt), 4);
    chk("full_we", 32'(s_we), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      chk("drain_data", 32'(s_od), 32'(seq4[i]));
      chk("drain_cnt", 32'(s_cnt), 32'(4 - i));
    end
    cyc(0, 0, 0, 0);
    chk("drained_ov", 32'(s_ov), 0);
    cyc(1, 8'hF0, 0, 0);
    cyc(1, 8'hF1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, W'(i), 1, 0);
      chk("stream_cnt", 32'(s_cnt), 2);
      chk("stream_data", 32'(s_od), i < 2 ? 32'(8'hF0 + i) : 32'(i - 2));
    end
    cyc(1, 8'h33, 0, 0);
    cyc(1, 8'h77, 1, 1);
    cyc(0, 0, 0, 0);
    chk("mid_rst_cnt", 32'(s_cnt), 0);
    chk("mid_rst_ov", 32'(s_ov), 0);
    cyc(1, 8'h5A, 1, 0);
`ifdef FIFO_BYPASS_EN
    chk("byp_ov", 32'(s_ov), 1);
    chk("byp_od", 32'(s_od), 32'h5A);
    chk("byp_we", 32'(s_we), 0);
    cyc(0, 0, 0, 0);
    chk("byp_cnt", 32'(s_cnt), 0);
`else
    chk("nobyp_ov0", 32'(s_ov), 0);
    cyc(0, 0, 1, 0);
    chk("nobyp_ov1", 32'(s_ov), 1);
    chk("nobyp_od", 32'(s_od), 32'h5A);
`endif
    for (int i = 0; i < 3000; i++) begin
      int ph;
      bit v, r, rs;
      ph = (i / 150) % 3;
      v  = (ph == 1) ? ($urandom % 8 != 0) : ($urandom % 2 == 0);
      r  = (ph == 2) ? ($urandom % 8 != 0) : ($urandom % 3 == 0);
      rs = ($urandom % 200 == 0);
      cyc(v, W'($urandom), r, rs);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
